// File: rtl/daq_pkg.sv
// daq_pkg: shared K-code constants, word-class and writer-state types for the DAQ write path
package daq_pkg;
  localparam logic [7:0] K_IDLE = 8'hF7;
  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_PAD = 8'h1C;
  typedef enum logic [2:0] {WC_NONE, WC_IDLE, WC_DATA, WC_PAD, WC_MIXED} wclass_t;
  typedef enum logic [1:0] {ST_WAIT_IDLE, ST_IDLE, ST_ACTIVE} state_t;
endpackage

// File: rtl/daq_word_classifier.sv
// daq_word_classifier: two-stage link word classification with matching two-cycle data delay
module daq_word_classifier
  import daq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   link_data,
  input  logic [DATA_W/8-1:0] link_is_k,
  input  logic                link_valid,
  output wclass_t             cls,
  output logic [DATA_W-1:0]   data
);
  localparam int NB = DATA_W / 8;
  logic [NB-1:0] k_q, k_d, idle_q, idle_d;
  logic vld_q, vld_d;
  logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;
  wclass_t cls_q, cls_d;
  always_comb begin
    idle_d = '0;
    for (int i = 0; i < NB; i++) idle_d[i] = link_is_k[i] && link_data[8*i +: 8] == K_IDLE;
    k_d = link_is_k;
    vld_d = link_valid;
    d1_d = link_data;
    d2_d = d1_q;
    cls_d = !vld_q ? WC_NONE : k_q == '0 ? WC_DATA : !(&k_q) ? WC_MIXED : &idle_q ? WC_IDLE : WC_PAD;
  end
  always_ff @(posedge clk)
    if (reset) begin
      k_q <= '0;
      idle_q <= '0;
      vld_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
      cls_q <= WC_NONE;
    end else begin
      k_q <= k_d;
      idle_q <= idle_d;
      vld_q <= vld_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      cls_q <= cls_d;
    end
  assign cls = cls_q;
  assign data = d2_q;
endmodule

// File: rtl/daq_event_writer.sv
// daq_event_writer: link-to-buffer event write engine with status RAM; DAQ_EVENT_WRITER_STATS_EN adds event/overflow/error counters
module daq_event_writer
  import daq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PTR_W = 11,
  parameter int BUF_ID_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   link_data,
  input  logic [DATA_W/8-1:0] link_is_k,
  input  logic                link_valid,
  input  logic [BUF_ID_W-1:0] w_buf_id,
  output logic [PTR_W-1:0]    w_ptr,
  output logic [DATA_W-1:0]   data_to_mem,
  output logic                mem_we,
  output logic                end_of_event,
  output logic [PTR_W:0]      end_len,
  output logic                end_ovf,
  input  logic                clk_io,
  input  logic [BUF_ID_W-1:0] r_buf_sel,
  output logic [PTR_W:0]      r_buf_len,
  output logic                r_buf_ovf
`ifdef DAQ_EVENT_WRITER_STATS_EN
  ,
  output logic [15:0]         evt_count,
  output logic [15:0]         ovf_count,
  output logic [15:0]         err_count
`endif
);
  wclass_t cls;
  logic [DATA_W-1:0] data;
  daq_word_classifier #(.DATA_W(DATA_W)) u_cls (
    .clk(clk), .reset(reset), .link_data(link_data), .link_is_k(link_is_k),
    .link_valid(link_valid), .cls(cls), .data(data)
  );
  state_t st_q, st_d;
  logic [BUF_ID_W-1:0] id1_q, id2_q, id_q, id_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, start, wr, close;
  logic [PTR_W+1:0] ram [2**BUF_ID_W];
  logic [PTR_W+1:0] rd_q;
  always_comb begin
    start = st_q == ST_IDLE && cls == WC_DATA;
    wr = (start || (st_q == ST_ACTIVE && cls == WC_DATA)) && !cnt_q[PTR_W] && !reset;
    close = st_q == ST_ACTIVE && cls == WC_IDLE && !reset;
    st_d = (st_q == ST_WAIT_IDLE && cls == WC_IDLE) || close ? ST_IDLE : start ? ST_ACTIVE : st_q;
    id_d = start ? id2_q : id_q;
    cnt_d = close ? '0 : wr ? cnt_q + (PTR_W+1)'(1) : cnt_q;
    ovf_d = start ? 1'b0 : (st_q == ST_ACTIVE && cls == WC_DATA && cnt_q[PTR_W]) ? 1'b1 : ovf_q;
  end
  // buffer ID travels with the word so it is latched from the first DATA word itself
  always_ff @(posedge clk)
    if (reset) begin
      st_q <= ST_WAIT_IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      id_q <= '0;
      id1_q <= '0;
      id2_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      id_q <= id_d;
      id1_q <= w_buf_id;
      id2_q <= id1_q;
    end
  always_ff @(posedge clk)
    if (close) ram[id_q] <= {ovf_q, cnt_q};
  always_ff @(posedge clk_io)
    rd_q <= ram[r_buf_sel];
  assign w_ptr = cnt_q[PTR_W-1:0];
  assign data_to_mem = data;
  assign mem_we = wr;
  assign end_of_event = close;
  assign end_len = cnt_q;
  assign end_ovf = ovf_q;
  assign {r_buf_ovf, r_buf_len} = rd_q;
`ifdef DAQ_EVENT_WRITER_STATS_EN
  logic [15:0] evt_q, evt_d, ovfc_q, ovfc_d, err_q, err_d;
  always_comb begin
    evt_d = evt_q + 16'(close);
    ovfc_d = ovfc_q + 16'(close && ovf_q);
    err_d = err_q + 16'(st_q != ST_WAIT_IDLE && cls == WC_MIXED);
  end
  always_ff @(posedge clk)
    if (reset) begin
      evt_q <= '0;
      ovfc_q <= '0;
      err_q <= '0;
    end else begin
      evt_q <= evt_d;
      ovfc_q <= ovfc_d;
      err_q <= err_d;
    end
  assign evt_count = evt_q;
  assign ovf_count = ovfc_q;
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_daq_event_writer.sv
// tb_daq_event_writer: randomized self-checking bench against a behavioural event/status model
module tb_daq_event_writer;
  import daq_pkg::*;
  logic clk = 0, clk_io = 0, reset = 1;
  logic [31:0] link_data = '0;
  logic [3:0] link_is_k = '0;
  logic link_valid = 0;
  logic [5:0] w_buf_id = '0, r_buf_sel = '0;
  logic [3:0] w_ptr;
  logic [31:0] data_to_mem;
  logic mem_we, end_of_event, end_ovf, r_buf_ovf;
  logic [4:0] end_len, r_buf_len;
`ifdef DAQ_EVENT_WRITER_STATS_EN
  logic [15:0] evt_count, ovf_count, err_count;
`endif
  daq_event_writer #(.DATA_W(32), .PTR_W(4), .BUF_ID_W(6)) dut (
    .clk(clk), .reset(reset), .link_data(link_data), .link_is_k(link_is_k),
    .link_valid(link_valid), .w_buf_id(w_buf_id), .w_ptr(w_ptr), .data_to_mem(data_to_mem),
    .mem_we(mem_we), .end_of_event(end_of_event), .end_len(end_len), .end_ovf(end_ovf),
    .clk_io(clk_io), .r_buf_sel(r_buf_sel), .r_buf_len(r_buf_len), .r_buf_ovf(r_buf_ovf)
`ifdef DAQ_EVENT_WRITER_STATS_EN
    , .evt_count(evt_count), .ovf_count(ovf_count), .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  always #7 clk_io = ~clk_io;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vec = 0, bad = 0;
  logic [63:0] obs[$], expq[$];
  // model: phase 0 = waiting for first IDLE after reset, 1 = between events, 2 = inside event
  int ph = 0, n = 0, m_evt = 0, m_ovfc = 0, m_err = 0;
  logic mo = 0;
  logic [5:0] mid = '0;
  logic [4:0] m_len [64];
  logic m_ovf [64];
  bit m_set [64];
  localparam logic [31:0] IDLE_W = {4{K_IDLE}};
  localparam logic [31:0] PAD_W = {K_PAD, K_COMMA, K_PAD, K_PAD};

  function automatic void model(logic v, logic [31:0] d, logic [3:0] k, logic [5:0] id, int c);
    bit is_idle = v && k == 4'hF && d == IDLE_W;
    bit is_data = v && k == 4'h0;
    bit is_mixed = v && k != 4'h0 && k != 4'hF;
    if (ph == 0) begin
      if (is_idle) ph = 1;
      return;
    end
    if (is_mixed) m_err++;
    if (is_data) begin
      if (ph == 1) begin ph = 2; n = 0; mo = 0; mid = id; end
      if (n < 16) begin expq.push_back({8'h00, 16'(c + 2), 8'(n), d}); n++; end
      else mo = 1;
    end else if (is_idle && ph == 2) begin
      expq.push_back({8'h01, 16'(c + 2), 8'(n), 31'b0, mo});
      m_len[mid] = 5'(n); m_ovf[mid] = mo; m_set[mid] = 1;
      m_evt++; if (mo) m_ovfc++;
      ph = 1;
    end
  endfunction

  task automatic step(logic v, logic [31:0] d, logic [3:0] k, logic [5:0] id);
    @(posedge clk); #1;
    link_valid = v; link_data = d; link_is_k = k; w_buf_id = id;
    if (!reset) model(v, d, k, id, cyc);
    @(negedge clk);
    if (!reset && mem_we) obs.push_back({8'h00, 16'(cyc), 8'(w_ptr), data_to_mem});
    if (!reset && end_of_event) obs.push_back({8'h01, 16'(cyc), 8'(end_len), 31'b0, end_ovf});
  endtask

  task automatic idle(logic [5:0] id); step(1, IDLE_W, 4'hF, id); endtask
  task automatic dat(logic [31:0] d, logic [5:0] id); step(1, d, 4'h0, id); endtask
  task automatic none(int cnt); repeat (cnt) step(0, '0, 4'h0, '0); endtask
  task automatic do_reset();
    reset = 1; none(3); reset = 0;
    ph = 0; m_evt = 0; m_ovfc = 0; m_err = 0;
  endtask
  task automatic rd(int sel);
    r_buf_sel = 6'(sel);
    repeat (2) @(posedge clk_io);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++; if (w_ptr !== 4'd0) begin bad++; $display("FAIL reset w_ptr: got %0d want 0", w_ptr); end
    vec++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we: got %b want 0", mem_we); end
    vec++; if (end_of_event !== 1'b0) begin bad++; $display("FAIL reset end_of_event: got %b want 0", end_of_event); end
    vec++; if (end_len !== 5'd0) begin bad++; $display("FAIL reset end_len: got %0d want 0", end_len); end
    vec++; if (end_ovf !== 1'b0) begin bad++; $display("FAIL reset end_ovf: got %b want 0", end_ovf); end
    vec++; if (data_to_mem !== 32'd0) begin bad++; $display("FAIL reset data_to_mem: got %h want 0", data_to_mem); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) dat(32'hA0 + i, 7);
    idle(7); idle(7);
    for (int i = 1; i <= 5; i++) dat(i, 7);
    idle(7); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL basic count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL basic ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    rd(7);
    vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[7], m_len[7]}) begin bad++; $display("FAIL basic readback 7: got %b/%0d want %b/%0d", r_buf_ovf, r_buf_len, m_ovf[7], m_len[7]); end
  endtask

  task automatic test_pad_id();
    for (int i = 0; i < 3; i++) dat($urandom, 3);
    step(1, PAD_W, 4'hF, 3); step(1, PAD_W, 4'hF, 9);
    for (int i = 0; i < 2; i++) dat($urandom, 9);
    idle(9); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL pad count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL pad ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    rd(3);
    vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[3], m_len[3]}) begin bad++; $display("FAIL pad readback 3: got %b/%0d want %b/%0d", r_buf_ovf, r_buf_len, m_ovf[3], m_len[3]); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) dat($urandom, 12);
    idle(12); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL ovf count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL ovf ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    rd(12);
    vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[12], m_len[12]}) begin bad++; $display("FAIL ovf readback 12: got %b/%0d want %b/%0d", r_buf_ovf, r_buf_len, m_ovf[12], m_len[12]); end
  endtask

  task automatic test_reset_mid();
    dat(32'h11, 7); dat(32'h22, 7); none(2);
    do_reset();
    rd(7);
    vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[7], m_len[7]}) begin bad++; $display("FAIL rstmid readback 7: got %b/%0d want %b/%0d", r_buf_ovf, r_buf_len, m_ovf[7], m_len[7]); end
    dat(32'h33, 7); dat(32'h44, 7); idle(7);
    for (int i = 0; i < 3; i++) dat($urandom, 7);
    idle(7); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL rstmid count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL rstmid ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    rd(7);
    vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[7], m_len[7]}) begin bad++; $display("FAIL rstmid readback 7 new: got %b/%0d want %b/%0d", r_buf_ovf, r_buf_len, m_ovf[7], m_len[7]); end
  endtask

  task automatic test_mixed();
    dat($urandom, 20); dat($urandom, 20);
    step(1, $urandom, 4'b0011, 20);
    dat($urandom, 20); idle(20); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL mixed count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL mixed ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
`ifdef DAQ_EVENT_WRITER_STATS_EN
    vec++; if (err_count !== 16'(m_err)) begin bad++; $display("FAIL mixed err_count: got %0d want %0d", err_count, m_err); end
`endif
  endtask

  task automatic test_back_to_back();
    dat(32'hB0, 0); idle(0); dat(32'hB1, 1); idle(1); none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL b2b count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL b2b ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    for (int s = 0; s < 2; s++) begin
      rd(s);
      vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[s], m_len[s]}) begin bad++; $display("FAIL b2b readback %0d: got %b/%0d want %b/%0d", s, r_buf_ovf, r_buf_len, m_ovf[s], m_len[s]); end
    end
  endtask

  task automatic test_random();
    repeat (40) begin
      automatic logic [5:0] id = 6'($urandom_range(0, 63));
      automatic int len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0: step(0, $urandom, 4'h0, id);
          1: step(1, $urandom, 4'hF, id);
          2: step(1, $urandom, 4'($urandom_range(1, 14)), id);
          default: ;
        endcase
        dat($urandom, id);
      end
      idle(id);
      if ($urandom_range(0, 2) == 0) idle(id);
    end
    none(4);
    vec++; if (obs.size() != expq.size()) begin bad++; $display("FAIL rand count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      vec++; if (obs[i] !== expq[i]) begin bad++; $display("FAIL rand ev%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    obs.delete(); expq.delete();
    for (int s = 0; s < 64; s++) if (m_set[s]) begin
      rd(s);
      vec++; if ({r_buf_ovf, r_buf_len} !== {m_ovf[s], m_len[s]}) begin bad++; $display("FAIL rand readback %0d: got %b/%0d want %b/%0d", s, r_buf_ovf, r_buf_len, m_ovf[s], m_len[s]); end
    end
`ifdef DAQ_EVENT_WRITER_STATS_EN
    vec++; if (evt_count !== 16'(m_evt)) begin bad++; $display("FAIL rand evt_count: got %0d want %0d", evt_count, m_evt); end
    vec++; if (ovf_count !== 16'(m_ovfc)) begin bad++; $display("FAIL rand ovf_count: got %0d want %0d", ovf_count, m_ovfc); end
    vec++; if (err_count !== 16'(m_err)) begin bad++; $display("FAIL rand err_count: got %0d want %0d", err_count, m_err); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad_id();
    test_overflow();
    test_reset_mid();
    test_mixed();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/daq_event_writer.md
Name: daq_event_writer

Overview:
Parametrised next-generation link-to-buffer write engine for the DAQ path. It classifies K-coded link words, writes event payload words into the selected event buffer, and records per-buffer length and overflow status in a small RAM that the clk_io domain reads back. Compared with the current writer it adds configurable widths, a resync state after reset, a start-of-event latched buffer ID, overflow/truncation handling and malformed-word detection.

Parameters:
DATA_W, 32, link word width; multiple of 8; NB = DATA_W/8 bytes
PTR_W, 11, buffer address width; buffer depth 2^PTR_W words
BUF_ID_W, 6, buffer ID width; 2^BUF_ID_W length/status entries

Ports:
clk  in  1  link/write clock
reset  in  1  synchronous, active-high (clk domain)
link_data  in  DATA_W  link word
link_is_k  in  NB  per-byte K flag
link_valid  in  1  word qualifier
w_buf_id  in  BUF_ID_W  target buffer; sampled at start of event
w_ptr  out  PTR_W  write address for the current data word
data_to_mem  out  DATA_W  write data
mem_we  out  1  write enable
end_of_event  out  1  one-cycle pulse when an event closes
end_len  out  PTR_W+1  words stored for the closed event; valid with end_of_event
end_ovf  out  1  closed event was truncated; valid with end_of_event
clk_io  in  1  readback clock
r_buf_sel  in  BUF_ID_W  readback entry select
r_buf_len  out  PTR_W+1  stored length of the selected entry
r_buf_ovf  out  1  stored overflow flag of the selected entry

Behaviour:
Pipeline:
- Stage 1 registers per-byte idle/K flags.
- Stage 2 registers the word class.
- mem_we, w_ptr and data_to_mem (link_data delayed 2 clk) are aligned at stage 2. Input-to-write latency is 2 clk.

Word class:
- NONE: link_valid=0.
- IDLE: all bytes K with value 8'hF7.
- DATA: no K bytes.
- PAD: all bytes K, not all IDLE.
- MIXED: some bytes K, some not; treated like PAD.

States:
- WAIT_IDLE (entered on reset): ignore everything until an IDLE word, then go to IDLE. Partial events after reset are never written.
- IDLE:
  - DATA: latch w_buf_id, write at w_ptr=0, clear ovf, go to ACTIVE.
  - Any other class: stay in IDLE.
- ACTIVE:
  - DATA: write at the next address.
  - PAD, MIXED, NONE: no write; state and pointer held.
  - IDLE: close the event and go to IDLE.

Word counter cnt (PTR_W+1 bits):
- Reset to 0 on reset and on event close.
- w_ptr = cnt[PTR_W-1:0].
- A DATA word is written only if cnt < 2^PTR_W; then cnt increments.
- Otherwise mem_we stays 0 and ovf is set (truncation). cnt saturates at 2^PTR_W.

Event close (the IDLE word while in ACTIVE):
- Write {ovf, cnt} into the status RAM at the latched ID.
- Pulse end_of_event in the same cycle, with end_len=cnt and end_ovf=ovf.
- Next cycle: cnt=0.

Reset values: w_ptr 0, mem_we 0, end_of_event 0, end_len 0, end_ovf 0, data_to_mem 0.

Status RAM:
- Not reset.
- Read side is registered: r_buf_len/r_buf_ovf update 1 clk_io cycle after r_buf_sel.
- A read of an entry in the same period it is being written returns undefined data. Software reads an entry only after it has seen the event complete.

Reset mid-event: the event is discarded, there is no end_of_event and no RAM write, and the block enters WAIT_IDLE.

Consecutive events: IDLE, then DATA on the next cycle, is legal. The new event starts at w_ptr=0.

Optional Feature:
Macro: DAQ_EVENT_WRITER_STATS_EN.
- Defined: adds outputs evt_count[15:0], ovf_count[15:0] and err_count[15:0] (clk domain).
  - Each increments on: event close; close with ovf; MIXED word received in IDLE or ACTIVE.
  - All counters wrap, and all reset to 0 on reset.
- Undefined: the counters and ports are absent, and all other behaviour is identical.

Decomposition:
- Package daq_pkg:
  - K constants: IDLE 8'hF7, COMMA 8'hBC, PAD 8'h1C.
  - Word-class enum: WC_NONE, WC_IDLE, WC_DATA, WC_PAD, WC_MIXED.
  - State enum: ST_WAIT_IDLE, ST_IDLE, ST_ACTIVE.
- Sub-module daq_word_classifier (parametrised on DATA_W): 2-stage classification plus data delay; outputs the word class and the delayed data.
- Top module: FSM, counter, status RAM.

Test Plan:
- Reset, then 3 DATA words with no preceding IDLE, then IDLE -> no mem_we and no end_of_event. Then IDLE, 5 DATA (0x1..0x5), IDLE with w_buf_id=7 -> writes 0x1..0x5 at w_ptr 0..4, 2 clk after input; end_len=5, end_ovf=0; r_buf_sel=7 gives r_buf_len=5.
- Event of 3 DATA, 2 PAD words, 2 DATA, then IDLE -> 5 writes with contiguous addresses 0..4; end_len=5. Change w_buf_id mid-event from 3 to 9 -> length is stored in entry 3.
- PTR_W=4, 20 DATA words -> 16 writes (w_ptr 0..15); end_len=16, end_ovf=1; r_buf_ovf=1.
- Reset asserted after 2 DATA words -> no end_of_event, entry unchanged. The next full event needs a leading IDLE.
- Word with link_is_k=4'b0011 inside an event -> no write, pointer held. With DAQ_EVENT_WRITER_STATS_EN: err_count=1.
- Back-to-back events (IDLE, 1 DATA, IDLE, 1 DATA, IDLE) on ids 0 and 1 -> two end_of_event pulses; both entries read back end_len=1.
